// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper_pkg
// Brief    : Shared types and constants for the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Golden table of F = AC + ABC' + BD + A'C'D', bit m is F at {A,B,C,D} = m
    localparam logic [15:0] F_EXPECTED = 16'hFCB1;
    localparam int          SETTLE_W   = 8;
    localparam int          MINTERMS   = 16;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper_if
// Brief    : Control, stimulus and result bundle of the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if;
    import truth_table_sweeper_pkg::*;

    logic                start;
    logic                abort;
    logic                f_in;
    logic                a_out;
    logic                b_out;
    logic                c_out;
    logic                d_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [MINTERMS-1:0] truth_table;
    logic [4:0]          mismatch_count;
    logic                first_fail_valid;
    logic [3:0]          first_fail_idx;

    modport master (
        output start, abort, f_in,
        input  a_out, b_out, c_out, d_out, busy, done, pass,
               truth_table, mismatch_count, first_fail_valid, first_fail_idx
    );

    modport slave (
        input  start, abort, f_in,
        output a_out, b_out, c_out, d_out, busy, done, pass,
               truth_table, mismatch_count, first_fail_valid, first_fail_idx
    );

endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : sweep_settle_timer
// Brief    : Loadable down-counter timing how long ABCD is held before sampling.
// Revision : 1.0 - initial release
// ============================================================================
module sweep_settle_timer
    import truth_table_sweeper_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    output logic                expired_o
);

    logic [SETTLE_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Expiry flags the last counted cycle so the caller leaves on the next edge
    assign expired_o = (count_q <= SETTLE_W'(1));

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Steps ABCD through all minterms, samples F and grades the table.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [MINTERMS-1:0] EXPECTED      = F_EXPECTED
)(
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  sw
);

    localparam logic [SETTLE_W-1:0] c_settle   = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [3:0]          c_last_idx = 4'(MINTERMS - 1);

    sweep_state_t        state_q;
    logic [3:0]          idx_q;
    logic [MINTERMS-1:0] tt_q;
    logic [4:0]          mm_q;
    logic [4:0]          mm_d;
    logic                ffv_q;
    logic [3:0]          ffi_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    logic                w_miss;
    logic                w_expired;
    logic                w_load;
    logic                w_en;

    always_comb begin
        w_miss = (sw.f_in != EXPECTED[idx_q]);
        mm_d   = mm_q + {4'd0, w_miss};
    end

    // Timer is parked at the reload value whenever it is not counting
    assign w_load = (state_q != SETTLE);
    assign w_en   = (state_q == SETTLE);

    sweep_settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .en_i       (w_en),
        .load_val_i (c_settle),
        .expired_o  (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sw.start && !sw.abort) begin
                        idx_q   <= '0;
                        tt_q    <= '0;
                        mm_q    <= '0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sw.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (w_expired) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // Capture commits even when this cycle is aborted
                    tt_q[idx_q] <= sw.f_in;
                    mm_q        <= mm_d;
                    if (w_miss && !ffv_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= idx_q;
                    end
                    if (sw.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (idx_q == c_last_idx) begin
                        done_q  <= 1'b1;
                        pass_q  <= (mm_d == 5'd0);
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sw.a_out            = idx_q[3];
    assign sw.b_out            = idx_q[2];
    assign sw.c_out            = idx_q[1];
    assign sw.d_out            = idx_q[0];
    assign sw.busy             = busy_q;
    assign sw.done             = done_q;
    assign sw.pass             = pass_q;
    assign sw.truth_table      = tt_q;
    assign sw.mismatch_count   = mm_q;
    assign sw.first_fail_valid = ffv_q;
    assign sw.first_fail_idx   = ffi_q;

endmodule
`default_nettype wire
